// File: rtl/skid_fifo_struct.sv
// Parametrised-depth valid/ready FIFO with synchronous flush, occupancy count and almost-full.
// Generalises the single-entry skid buffer; read side is combinational from registered state.
module skid_fifo_struct #(
   parameter type         T            = logic [31:0],
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [$bits(T)-1:0]          data_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [$bits(T)-1:0]          data_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int unsigned W  = $bits(T);
   localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic full, empty, push, pop;

   // Explicit wrap so non-power-of-two depths index only valid entries.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full        = (count_q == DEPTH_C);
      empty       = (count_q == '0);
      ready_in    = (!full || ready_out) && !flush;
      valid_out   = !empty && !flush;
      push        = valid_in && ready_in;
      pop         = valid_out && ready_out;
      data_out    = mem_q[rd_ptr_q];
      count       = count_q;
      almost_full = (count_q >= AFULL_C);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   a_count_bound : assert property (@(posedge clk) count_q <= DEPTH_C);

   a_head_stable : assert property (@(posedge clk) disable iff (!reset)
      (valid_out && !ready_out && !flush) |=> $stable(data_out));

endmodule

// File: tb/tb_skid_fifo_struct.sv
// Scoreboard bench for skid_fifo_struct (8-bit payload, DEPTH=4, AFULL_THRESH=3).
module tb_skid_fifo_struct;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AFT   = 3;

   logic       clk = 1'b0;
   logic       reset, flush, valid_in, ready_in, valid_out, ready_out, almost_full;
   logic [7:0] data_in, data_out;
   logic [2:0] count;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          known = 1'b0;
   logic [7:0]  sb [$];

   skid_fifo_struct #(
      .T            (logic [7:0]),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .data_in     (data_in),
      .valid_out   (valid_out),
      .ready_out   (ready_out),
      .data_out    (data_out),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, check outputs against the model, update the model after posedge.
   task automatic step(input bit vin, input logic [7:0] din, input bit rout,
                       input bit fl, input bit rst);
      bit e_rdy, e_vout, acc, take;
      logic [7:0] head;
      @(negedge clk);
      valid_in  = vin;
      data_in   = din;
      ready_out = rout;
      flush     = fl;
      reset     = rst;
      #1;
      e_rdy  = ((sb.size() != DEPTH) || rout) && !fl;
      e_vout = (sb.size() != 0) && !fl;
      acc    = vin && e_rdy;
      take   = e_vout && rout;
      if (known) begin
         check("count",       count,       sb.size());
         check("almost_full", almost_full, (sb.size() >= AFT) ? 1 : 0);
         check("ready_in",    ready_in,    e_rdy);
         check("valid_out",   valid_out,   e_vout);
         if (e_vout && !take) check("head", data_out, sb[0]);
      end
      @(posedge clk);
      if (!rst || !known) begin
         sb.delete();
         known = known || !rst;
      end else if (fl) begin
         sb.delete();
      end else begin
         if (take) begin
            head = sb.pop_front();
            check("pop_data", data_out, head);
         end
         if (acc) sb.push_back(din);
      end
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;

      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 0, 1);

      step(1, 8'h11, 0, 0, 1);
      step(1, 8'h22, 0, 0, 1);
      step(1, 8'h33, 0, 0, 1);
      step(1, 8'h44, 0, 0, 1);
      step(1, 8'h55, 0, 0, 1);

      step(1, 8'h55, 1, 0, 1);

      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1);

      step(1, 8'hA1, 0, 0, 1);
      step(1, 8'hA2, 0, 0, 1);
      step(1, 8'hA3, 0, 0, 1);
      step(1, 8'hA4, 1, 1, 1);
      step(0, 8'h00, 0, 0, 1);

      step(1, 8'hB1, 0, 0, 1);
      step(1, 8'hB2, 0, 0, 1);
      step(1, 8'hB3, 0, 0, 0);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);

      // Push/pop at count=1 and steady streaming through the wrap.
      step(1, 8'hC1, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 8'(8'hC2 + i), 1, 0, 1);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 79) != 0));

      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
